// File: rtl/gcount_pkg.sv
// Shared constants and pipeline-stage type for the Gray-count sampler.
package gcount_pkg;

    localparam int unsigned GCOUNT_W      = 32;
    localparam int unsigned GCOUNT_STAGES = 4;
    localparam int unsigned DROP_CNT_W    = 8;

    // One conversion stage: unresolved Gray bits travel alongside the binary
    // bits resolved so far.
    typedef struct packed {
        logic                valid;
        logic [GCOUNT_W-1:0] gray;
        logic [GCOUNT_W-1:0] bin;
    } stage_t;

endpackage

// File: rtl/gcount_sampler_if.sv
// Result interface from the sampler to the power-monitor logic.
interface gcount_sampler_if
    import gcount_pkg::*;
#(
    parameter int unsigned W = GCOUNT_W
) ();

    logic [W-1:0]          bin_o;
    logic [W-1:0]          delta_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  drop_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o;

    modport master (
        output bin_o,
        output delta_o,
        output valid_o,
        output drop_o,
        output drop_cnt_o,
        input  ready_i
    );

    modport slave (
        input  bin_o,
        input  delta_o,
        input  valid_o,
        input  drop_o,
        input  drop_cnt_o,
        output ready_i
    );

endinterface

// File: rtl/gray2bin_stage.sv
// One registered slice of the Gray-to-binary conversion, resolving bits Hi..Lo
// using the lowest bit resolved by the previous slice as carry-in.
module gray2bin_stage
    import gcount_pkg::*;
#(
    parameter int unsigned Hi = GCOUNT_W - 1,
    parameter int unsigned Lo = GCOUNT_W - GCOUNT_W / GCOUNT_STAGES
) (
    input  logic   clk,
    input  logic   reset,
    input  stage_t stage_i,
    output stage_t stage_o
);

    stage_t stage_d, stage_q;
    logic   carry_in;

    // chain[j] is binary bit Lo+j; the extra top bit is the carry-in
    logic [Hi-Lo+1:0] chain;

    if (Hi == GCOUNT_W - 1) begin : g_first
        assign carry_in = 1'b0;
    end else begin : g_next
        assign carry_in = stage_i.bin[Hi+1];
    end

    assign chain[Hi-Lo+1] = carry_in;

    for (genvar j = 0; j <= int'(Hi - Lo); j++) begin : g_xor
        assign chain[j] = chain[j+1] ^ stage_i.gray[Lo+j];
    end

    // Pass the stage through, overwriting this slice with resolved binary bits
    always_comb begin
        stage_d             = stage_i;
        stage_d.bin[Hi:Lo]  = chain[Hi-Lo:0];
    end

    // Stage register; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/gcount_sampler.sv
// Synchronises a free-running Gray count, captures it on sample_i, converts it
// to binary over four stages and presents value plus delta on a valid/ready port.
module gcount_sampler
    import gcount_pkg::*;
#(
    // Must equal GCOUNT_W: the stage struct is sized from the package
    parameter int unsigned W           = GCOUNT_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [W-1:0]            gray_i,
    input  logic                    sample_i,
    gcount_sampler_if.master        out_if
);

    localparam int unsigned SliceW = W / GCOUNT_STAGES;

    logic [W-1:0] gray_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign gray_s = gray_i;
    end else begin : g_sync
        logic [W-1:0] sync_d [SYNC_STAGES];
        logic [W-1:0] sync_q [SYNC_STAGES];

        // Shift chain; single-bit Gray changes make the crossing safe
        always_comb begin
            sync_d[0] = gray_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        // Synchroniser flops
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '{default: '0};
            end else begin
                sync_q <= sync_d;
            end
        end

        assign gray_s = sync_q[SYNC_STAGES-1];
    end

    stage_t pipe [GCOUNT_STAGES+1];

    // Stage-1 input: the pipeline never stalls, every strobe enters
    always_comb begin
        pipe[0]       = '0;
        pipe[0].valid = sample_i;
        pipe[0].gray  = gray_s;
    end

    for (genvar k = 0; k < int'(GCOUNT_STAGES); k++) begin : g_stage
        gray2bin_stage #(
            .Hi(W - 1 - k * SliceW),
            .Lo(W - (k + 1) * SliceW)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .stage_i(pipe[k]),
            .stage_o(pipe[k+1])
        );
    end

    logic         res_valid;
    logic [W-1:0] res_bin;
    logic         unused_gray;

    assign res_valid   = pipe[GCOUNT_STAGES].valid;
    assign res_bin     = pipe[GCOUNT_STAGES].bin;
    assign unused_gray = ^pipe[GCOUNT_STAGES].gray;

    logic                  valid_d, valid_q;
    logic [W-1:0]          bin_d, bin_q;
    logic [W-1:0]          delta_d, delta_q;
    logic                  drop_d, drop_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;
    logic                  load;

    // Load when the slot is free or being drained this cycle, else drop.
    // bin_q doubles as the previous accepted value: both change only on a load
    // and both reset to zero.
    always_comb begin
        load       = res_valid & (~valid_q | out_if.ready_i);
        drop_d     = res_valid & valid_q & ~out_if.ready_i;
        valid_d    = valid_q;
        bin_d      = bin_q;
        delta_d    = delta_q;
        drop_cnt_d = drop_cnt_q;
        if (load) begin
            valid_d = 1'b1;
            bin_d   = res_bin;
            delta_d = res_bin - bin_q;
        end else if (out_if.ready_i) begin
            valid_d = 1'b0;
        end
        if (drop_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Output register and drop bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            bin_q      <= '0;
            delta_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            bin_q      <= bin_d;
            delta_q    <= delta_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_if.valid_o    = valid_q;
    assign out_if.bin_o      = bin_q;
    assign out_if.delta_o    = delta_q;
    assign out_if.drop_o     = drop_q;
    assign out_if.drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_gcount_sampler.sv
// Self-checking bench for gcount_sampler: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_gcount_sampler;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] gray_i = '0;
    logic         sample_i = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gcount_sampler_if #(.W(W)) out_if ();

    gcount_sampler #(
        .W          (W),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .gray_i  (gray_i),
        .sample_i(sample_i),
        .out_if  (out_if)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    typedef struct {
        int           due;
        logic [W-1:0] bin;
    } arr_t;

    arr_t         mq[$];
    int           ecnt    = 0;
    logic [W-1:0] m_h1    = '0;
    logic [W-1:0] m_h2    = '0;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_bin   = '0;
    logic [W-1:0] m_delta = '0;
    logic         m_drop  = 1'b0;
    logic [7:0]   m_cnt   = '0;

    // Result of a strobe at edge S is offered at edge S+4; gray seen by the
    // strobe is the input value from two edges earlier.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_valid <= 1'b0;
            m_bin   <= '0;
            m_delta <= '0;
            m_drop  <= 1'b0;
            m_cnt   <= '0;
            m_h1    <= '0;
            m_h2    <= '0;
        end else begin
            if (mq.size() > 0 && mq[0].due == ecnt) begin
                if (!m_valid || out_if.ready_i) begin
                    m_valid <= 1'b1;
                    m_bin   <= mq[0].bin;
                    m_delta <= mq[0].bin - m_bin;
                    m_drop  <= 1'b0;
                end else begin
                    m_drop <= 1'b1;
                    if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
                end
                void'(mq.pop_front());
            end else begin
                m_drop <= 1'b0;
                if (out_if.ready_i) m_valid <= 1'b0;
            end
            if (sample_i) mq.push_back('{ecnt + 4, g2b(m_h2)});
            m_h2 <= m_h1;
            m_h1 <= gray_i;
        end
        ecnt <= ecnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset    = 1'b1;
        sample_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Hold g long enough to cross the synchroniser, strobe once, and stop at
    // the negedge after the result's load edge.
    task automatic do_sample(input logic [W-1:0] g);
        gray_i = g;
        repeat (3) tick();
        sample_i = 1'b1;
        tick();
        sample_i = 1'b0;
        repeat (4) tick();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        out_if.ready_i = 1'b0;
        gray_i         = '0;
        reset_dut();
        @(negedge clk);
        n_cmp++;
        if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b bin=%h d=%h drop=%b cnt=%0d, want all zero",
                     out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o);
        end
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (out_if.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_valid: got %b want 0", out_if.valid_o);
        end
    endtask

    task automatic test_single();
        reset_dut();
        out_if.ready_i = 1'b1;
        gray_i         = 32'h0000_0007;
        repeat (3) tick();
        sample_i = 1'b1;
        tick();
        sample_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (out_if.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid: got %b want 0", out_if.valid_o);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({out_if.valid_o, out_if.bin_o, out_if.delta_o} !== {1'b1, 32'h5, 32'h5}) begin
            n_fail++;
            $display("FAIL single_result: got v=%b bin=%h d=%h want v=1 bin=00000005 d=00000005",
                     out_if.valid_o, out_if.bin_o, out_if.delta_o);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (out_if.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consumed: got valid %b want 0", out_if.valid_o);
        end
    endtask

    task automatic test_msb_wrap();
        out_if.ready_i = 1'b1;
        do_sample(32'h8000_0000);
        n_cmp++;
        if ({out_if.valid_o, out_if.bin_o} !== {1'b1, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL msb_bin: got v=%b bin=%h want v=1 bin=ffffffff",
                     out_if.valid_o, out_if.bin_o);
        end
        do_sample(32'h0000_0001);
        n_cmp++;
        if ({out_if.valid_o, out_if.bin_o, out_if.delta_o} !== {1'b1, 32'h1, 32'h2}) begin
            n_fail++;
            $display("FAIL wrap_delta: got v=%b bin=%h d=%h want v=1 bin=00000001 d=00000002",
                     out_if.valid_o, out_if.bin_o, out_if.delta_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] k0;
        logic [W-1:0] last;
        int           seen;
        k0             = 32'hFFFF_FFF0;
        last           = '0;
        seen           = 0;
        out_if.ready_i = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            gray_i   = b2g(k0 + W'(c));
            sample_i = (c >= 2 && c < 42);
            @(negedge clk);
            n_cmp++;
            if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !==
                {m_valid, m_bin, m_delta, m_drop, m_cnt}) begin
                n_fail++;
                $display("FAIL b2b_model c=%0d: got %h want %h", c,
                         {out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o},
                         {m_valid, m_bin, m_delta, m_drop, m_cnt});
            end
            n_cmp++;
            if (out_if.drop_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_no_drop c=%0d: got drop %b want 0", c, out_if.drop_o);
            end
            if (out_if.valid_o === 1'b1) begin
                if (seen > 0) begin
                    n_cmp++;
                    if ({out_if.bin_o, out_if.delta_o} !== {last + 32'd1, 32'd1}) begin
                        n_fail++;
                        $display("FAIL b2b_step c=%0d: got bin=%h d=%h want bin=%h d=00000001",
                                 c, out_if.bin_o, out_if.delta_o, last + 32'd1);
                    end
                end
                last = out_if.bin_o;
                seen++;
            end
        end
        sample_i = 1'b0;
        n_cmp++;
        if (seen != 40) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results want 40", seen);
        end
    endtask

    task automatic test_backpressure();
        int ndrop;
        ndrop = 0;
        out_if.ready_i = 1'b0;
        reset_dut();
        for (int c = 0; c < 36; c++) begin
            tick();
            gray_i         = b2g(W'(100 + c));
            sample_i       = (c == 4 || c == 8 || c == 12 || c == 24);
            out_if.ready_i = (c >= 20);
            @(negedge clk);
            n_cmp++;
            if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !==
                {m_valid, m_bin, m_delta, m_drop, m_cnt}) begin
                n_fail++;
                $display("FAIL bp_model c=%0d: got %h want %h", c,
                         {out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o},
                         {m_valid, m_bin, m_delta, m_drop, m_cnt});
            end
            if (out_if.drop_o === 1'b1) ndrop++;
            if (c >= 9 && c <= 20) begin
                n_cmp++;
                if ({out_if.valid_o, out_if.bin_o, out_if.delta_o} !== {1'b1, 32'd102, 32'd102}) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d: got v=%b bin=%h d=%h want v=1 bin=%h d=%h",
                             c, out_if.valid_o, out_if.bin_o, out_if.delta_o, 32'd102, 32'd102);
                end
            end
            if (c == 19) begin
                n_cmp++;
                if (out_if.drop_cnt_o !== 8'd2) begin
                    n_fail++;
                    $display("FAIL bp_drop_cnt: got %0d want 2", out_if.drop_cnt_o);
                end
            end
            if (c >= 21 && c <= 28) begin
                n_cmp++;
                if (out_if.valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_drained c=%0d: got valid %b want 0", c, out_if.valid_o);
                end
            end
            if (c == 29) begin
                n_cmp++;
                if ({out_if.valid_o, out_if.bin_o, out_if.delta_o} !== {1'b1, 32'd122, 32'd20}) begin
                    n_fail++;
                    $display("FAIL bp_span_delta: got v=%b bin=%h d=%h want v=1 bin=%h d=%h",
                             out_if.valid_o, out_if.bin_o, out_if.delta_o, 32'd122, 32'd20);
                end
            end
        end
        n_cmp++;
        if (ndrop != 2) begin
            n_fail++;
            $display("FAIL bp_drop_pulses: got %0d want 2", ndrop);
        end
    endtask

    task automatic test_saturation();
        out_if.ready_i = 1'b0;
        reset_dut();
        for (int c = 0; c < 320; c++) begin
            tick();
            gray_i   = b2g(W'(c * 7));
            sample_i = (c < 310);
            @(negedge clk);
            n_cmp++;
            if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !==
                {m_valid, m_bin, m_delta, m_drop, m_cnt}) begin
                n_fail++;
                $display("FAIL sat_model c=%0d: got %h want %h", c,
                         {out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o},
                         {m_valid, m_bin, m_delta, m_drop, m_cnt});
            end
            if (c == 300) begin
                n_cmp++;
                if ({out_if.drop_o, out_if.drop_cnt_o} !== {1'b1, 8'd255}) begin
                    n_fail++;
                    $display("FAIL sat_pulse: got drop=%b cnt=%0d want drop=1 cnt=255",
                             out_if.drop_o, out_if.drop_cnt_o);
                end
            end
        end
        n_cmp++;
        if (out_if.drop_cnt_o !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final: got %0d want 255", out_if.drop_cnt_o);
        end
    endtask

    task automatic test_reset_midflight();
        out_if.ready_i = 1'b0;
        reset_dut();
        for (int c = 0; c < 30; c++) begin
            tick();
            gray_i         = b2g(W'(500 + c));
            sample_i       = (c == 2 || c == 10 || c == 22);
            reset          = (c == 12 || c == 13);
            out_if.ready_i = (c >= 22);
            @(negedge clk);
            n_cmp++;
            if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !==
                {m_valid, m_bin, m_delta, m_drop, m_cnt}) begin
                n_fail++;
                $display("FAIL mid_model c=%0d: got %h want %h", c,
                         {out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o},
                         {m_valid, m_bin, m_delta, m_drop, m_cnt});
            end
            if (c == 11) begin
                n_cmp++;
                if ({out_if.valid_o, out_if.bin_o} !== {1'b1, 32'd500}) begin
                    n_fail++;
                    $display("FAIL mid_pre_reset: got v=%b bin=%h want v=1 bin=%h",
                             out_if.valid_o, out_if.bin_o, 32'd500);
                end
            end
            if (c >= 13 && c <= 21) begin
                n_cmp++;
                if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !== '0) begin
                    n_fail++;
                    $display("FAIL mid_flushed c=%0d: got v=%b bin=%h d=%h drop=%b cnt=%0d want all zero",
                             c, out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o,
                             out_if.drop_cnt_o);
                end
            end
            if (c == 27) begin
                n_cmp++;
                if ({out_if.valid_o, out_if.bin_o, out_if.delta_o} !== {1'b1, 32'd520, 32'd520}) begin
                    n_fail++;
                    $display("FAIL mid_first_delta: got v=%b bin=%h d=%h want v=1 bin=%h d=%h",
                             out_if.valid_o, out_if.bin_o, out_if.delta_o, 32'd520, 32'd520);
                end
            end
        end
        sample_i = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            tick();
            gray_i         = $urandom;
            sample_i       = 1'($urandom_range(0, 1));
            out_if.ready_i = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            n_cmp++;
            if ({out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o} !==
                {m_valid, m_bin, m_delta, m_drop, m_cnt}) begin
                n_fail++;
                $display("FAIL rand_model c=%0d: got %h want %h", c,
                         {out_if.valid_o, out_if.bin_o, out_if.delta_o, out_if.drop_o, out_if.drop_cnt_o},
                         {m_valid, m_bin, m_delta, m_drop, m_cnt});
            end
        end
        reset    = 1'b0;
        sample_i = 1'b0;
    endtask

    initial begin
        out_if.ready_i = 1'b0;
        test_reset();
        test_single();
        test_msb_wrap();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
